// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: mode encoding and idle output pattern.
// Latency: n/a (constants and a constant-foldable helper only).
// Backpressure: n/a.
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest output vector any legal parameter set can produce (SEL_W <= 6).
    localparam int MAX_CHANNELS = 64;

    // All-ones idle pattern for the low 'channels' bits. The result is
    // MAX_CHANNELS wide. Callers keep the low CHANNELS bits.
    function automatic logic [MAX_CHANNELS-1:0] idle_pattern(input int channels);
        logic [MAX_CHANNELS-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (i < channels) begin
                p[i] = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler for scan mode: produces a one-cycle tick every div+1 running cycles.
// Latency: tick is combinational from the registered count (same-cycle as compare).
// Backpressure: none; 'run' low freezes the count, 'clr' forces it to zero.
//
// Ports:
//   clk, rst_n : clock and async active-low reset
//   run        : enabled and in scan mode; count advances only when high
//   clr        : hold count at zero (direct mode); has priority over run
//   div        : dwell divisor; tick when count >= div
//   tick       : advance strobe for the channel select
module scan_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             expired;

    // >= rather than == so that lowering div below the current count
    // advances on the next running cycle instead of wrapping the counter.
    assign expired = (cnt_q >= div);
    assign tick    = run & expired;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = expired ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered 138-style decoder with direct select or prescaled scanning select.
// Latency: 1 clock from sel/enables to y_n, cur_sel, wrap and active.
// Backpressure: none; disabling freezes scan position and prescaler, y_n idles high.
//
// Ports:
//   clk, rst_n          : clock and async active-low reset
//   g1, g2a_n, g2b_n    : enables (high, low, low)
//   mode                : 0 direct, 1 scan
//   sel                 : direct-mode select
//   div                 : scan dwell, each channel held div+1 enabled clocks
//   y_n                 : one-hot-low outputs
//   cur_sel             : channel currently decoded
//   wrap                : one-cycle pulse on the advance that lands on channel 0
//   active              : registered enable
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W    = 3,
    parameter int CHANNELS = 8,
    parameter int DIV_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                g1,
    input  logic                g2a_n,
    input  logic                g2b_n,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [DIV_W-1:0]    div,
    output logic [CHANNELS-1:0] y_n,
    output logic [SEL_W-1:0]    cur_sel,
    output logic                wrap,
    output logic                active
);

    localparam logic [MAX_CHANNELS-1:0] IDLE_FULL = idle_pattern(CHANNELS);
    localparam logic [CHANNELS-1:0]     IDLE      = IDLE_FULL[CHANNELS-1:0];
    localparam logic [SEL_W-1:0]        LAST_SEL  = SEL_W'(CHANNELS - 1);

    logic                en;
    logic                tick;
    logic                scan_mode;

    logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
    logic [CHANNELS-1:0] y_n_q,     y_n_d;
    logic                wrap_q,    wrap_d;
    logic                active_q;

    assign en        = g1 & ~g2a_n & ~g2b_n;
    assign scan_mode = (mode == MODE_SCAN);

    scan_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (en & scan_mode),
        .clr   (~scan_mode),
        .div   (div),
        .tick  (tick)
    );

    // Next select. A disabled decoder freezes its position in both modes.
    // The advance treats anything at or above the last channel as the end of
    // the scan, so an out-of-range value left by direct mode goes to 0.
    always_comb begin
        cur_sel_d = cur_sel_q;
        wrap_d    = 1'b0;
        if (en) begin
            if (!scan_mode) begin
                cur_sel_d = sel;
            end else if (tick) begin
                if (cur_sel_q >= LAST_SEL) begin
                    cur_sel_d = '0;
                    wrap_d    = 1'b1;
                end else begin
                    cur_sel_d = cur_sel_q + 1'b1;
                end
            end
        end
    end

    // Decode from the same next-select value that cur_sel registers, so the
    // two outputs can never disagree. Selects >= CHANNELS match no bit.
    always_comb begin
        y_n_d = IDLE;
        if (en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cur_sel_d == SEL_W'(i)) begin
                    y_n_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel_q <= '0;
            y_n_q     <= IDLE;
            wrap_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            cur_sel_q <= cur_sel_d;
            y_n_q     <= y_n_d;
            wrap_q    <= wrap_d;
            active_q  <= en;
        end
    end

    assign y_n     = y_n_q;
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;
    assign active  = active_q;

endmodule
